// File: rtl/dbus_sram_responder.sv
// D-bus responder that services single load/store cycles from a 16-bit asynchronous SRAM.
// Each access is split into 1/2/4 halfword beats with a programmable strobe width.
module dbus_sram_responder #(
  parameter int ADR_W       = 20,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              dcyc_i,
  input  logic              dstb_i,
  input  logic              dwe_i,
  input  logic [63:0]       dadr_i,
  input  logic [63:0]       ddat_i,
  input  logic [1:0]        dsiz_i,
  input  logic              dsigned_i,
  output logic [63:0]       ddat_o,
  output logic              dack_o,
  output logic [ADR_W-1:0]  sram_adr_o,
  input  logic [15:0]       sram_dat_i,
  output logic [15:0]       sram_dat_o,
  output logic              sram_dat_oe_o,
  output logic              sram_cs_no,
  output logic              sram_oe_no,
  output logic              sram_we_no,
  output logic              sram_ub_no,
  output logic              sram_lb_no
);

  // Handshake: a request is accepted only in IDLE when dcyc_i & dstb_i are both high;
  // completion is a single-cycle dack_o, and an access dropped via dcyc_i is never acked.
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, ACK} state_e;

  localparam logic [3:0] WS_LAST = 4'(WAIT_STATES);

  state_e            state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic [3:0]        ws_q, ws_d;
  logic              we_q, we_d;
  logic [1:0]        siz_q, siz_d;
  logic              sgn_q, sgn_d;
  logic [63:0]       wdat_q, wdat_d;
  logic [ADR_W:0]    adr_q, adr_d;
  logic [63:0]       asm_q, asm_d;
  logic [1:0]        last_k;

  logic [ADR_W-1:0]  base;
  logic [7:0]        bsel;
  logic [63:0]       result;
  logic              active;

  logic [ADR_W-1:0]  sram_adr_d;
  logic [15:0]       sram_dat_d;
  logic              dat_oe_d, cs_n_d, oe_n_d, we_n_d, ub_n_d, lb_n_d, dack_d;
  logic [63:0]       ddat_d;

  logic              unused_adr;
  assign unused_adr = ^dadr_i[63:ADR_W+1];

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    ws_d    = ws_q;
    we_d    = we_q;
    siz_d   = siz_q;
    sgn_d   = sgn_q;
    wdat_d  = wdat_q;
    adr_d   = adr_q;
    asm_d   = asm_q;
    last_k  = (siz_q == 2'd3) ? 2'd3 : (siz_q == 2'd2) ? 2'd1 : 2'd0;
    case (state_q)
      IDLE: begin
        if (dcyc_i && dstb_i) begin
          we_d    = dwe_i;
          siz_d   = dsiz_i;
          sgn_d   = dsigned_i;
          wdat_d  = ddat_i;
          adr_d   = dadr_i[ADR_W:0];
          asm_d   = '0;
          k_d     = 2'd0;
          ws_d    = 4'd0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        ws_d    = 4'd0;
        state_d = STROBE;
      end
      STROBE: begin
        if (ws_q == WS_LAST) begin
          if (!we_q) asm_d[{k_q, 4'b0000} +: 16] = sram_dat_i;
          if (!dcyc_i) begin
            state_d = IDLE;
          end else if (k_q == last_k) begin
            state_d = ACK;
          end else begin
            k_d     = k_q + 2'd1;
            state_d = SETUP;
          end
        end else begin
          ws_d = ws_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pin values are computed from the next state so every SRAM control is a plain flop.
  always_comb begin
    base = adr_d[ADR_W:1];
    if (siz_d == 2'd2) base[0] = 1'b0;
    else if (siz_d == 2'd3) base[1:0] = 2'b00;
    active     = (state_d == SETUP) || (state_d == STROBE);
    sram_adr_d = base + {{(ADR_W-2){1'b0}}, k_d};
    sram_dat_d = (siz_d == 2'd0) ? {wdat_d[7:0], wdat_d[7:0]} : wdat_d[{k_d, 4'b0000} +: 16];
    dat_oe_d   = active && we_d;
    cs_n_d     = !active;
    oe_n_d     = !((state_d == STROBE) && !we_d);
    we_n_d     = !((state_d == STROBE) && we_d);
    ub_n_d     = 1'b1;
    lb_n_d     = 1'b1;
    if (active) begin
      if (we_d && (siz_d == 2'd0)) begin
        ub_n_d = !adr_d[0];
        lb_n_d = adr_d[0];
      end else begin
        ub_n_d = 1'b0;
        lb_n_d = 1'b0;
      end
    end
    bsel = adr_d[0] ? asm_d[15:8] : asm_d[7:0];
    case (siz_d)
      2'd0:    result = {{56{sgn_d & bsel[7]}}, bsel};
      2'd1:    result = {{48{sgn_d & asm_d[15]}}, asm_d[15:0]};
      2'd2:    result = {{32{sgn_d & asm_d[31]}}, asm_d[31:0]};
      default: result = asm_d;
    endcase
    dack_d = (state_d == ACK);
    ddat_d = (dack_d && !we_d) ? result : 64'd0;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= IDLE;
      k_q           <= '0;
      ws_q          <= '0;
      we_q          <= 1'b0;
      siz_q         <= '0;
      sgn_q         <= 1'b0;
      wdat_q        <= '0;
      adr_q         <= '0;
      asm_q         <= '0;
      sram_adr_o    <= '0;
      sram_dat_o    <= '0;
      sram_dat_oe_o <= 1'b0;
      sram_cs_no    <= 1'b1;
      sram_oe_no    <= 1'b1;
      sram_we_no    <= 1'b1;
      sram_ub_no    <= 1'b1;
      sram_lb_no    <= 1'b1;
      dack_o        <= 1'b0;
      ddat_o        <= '0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      ws_q          <= ws_d;
      we_q          <= we_d;
      siz_q         <= siz_d;
      sgn_q         <= sgn_d;
      wdat_q        <= wdat_d;
      adr_q         <= adr_d;
      asm_q         <= asm_d;
      sram_adr_o    <= sram_adr_d;
      sram_dat_o    <= sram_dat_d;
      sram_dat_oe_o <= dat_oe_d;
      sram_cs_no    <= cs_n_d;
      sram_oe_no    <= oe_n_d;
      sram_we_no    <= we_n_d;
      sram_ub_no    <= ub_n_d;
      sram_lb_no    <= lb_n_d;
      dack_o        <= dack_d;
      ddat_o        <= ddat_d;
    end
  end

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Bench for dbus_sram_responder: table of directed accesses against an SRAM model,
// plus hand sequences for mid-beat reset and a dcyc_i abort.
module tb_dbus_sram_responder;
  localparam int ADR_W = 20;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              dcyc, dstb, dwe, dsigned;
  logic [63:0]       dadr, ddat_in;
  logic [1:0]        dsiz;
  logic [63:0]       ddat_o;
  logic              dack_o;
  logic [ADR_W-1:0]  sram_adr_o;
  logic [15:0]       sram_dat_i, sram_dat_o;
  logic              sram_dat_oe_o, sram_cs_no, sram_oe_no, sram_we_no, sram_ub_no, sram_lb_no;

  always #5 clk = ~clk;

  dbus_sram_responder #(.ADR_W(ADR_W), .WAIT_STATES(1)) dut (
    .clk_i(clk), .reset_ni(reset_n), .dcyc_i(dcyc), .dstb_i(dstb), .dwe_i(dwe),
    .dadr_i(dadr), .ddat_i(ddat_in), .dsiz_i(dsiz), .dsigned_i(dsigned),
    .ddat_o(ddat_o), .dack_o(dack_o), .sram_adr_o(sram_adr_o), .sram_dat_i(sram_dat_i),
    .sram_dat_o(sram_dat_o), .sram_dat_oe_o(sram_dat_oe_o), .sram_cs_no(sram_cs_no),
    .sram_oe_no(sram_oe_no), .sram_we_no(sram_we_no), .sram_ub_no(sram_ub_no),
    .sram_lb_no(sram_lb_no)
  );

  // Asynchronous SRAM model (64 halfwords)
  logic [15:0] mem [0:63];
  assign sram_dat_i = (!sram_cs_no && !sram_oe_no) ? mem[sram_adr_o[5:0]] : 16'h0000;
  always @(negedge clk) begin
    if (!sram_cs_no && !sram_we_no) begin
      if (!sram_lb_no) mem[sram_adr_o[5:0]][7:0]  <= sram_dat_o[7:0];
      if (!sram_ub_no) mem[sram_adr_o[5:0]][15:8] <= sram_dat_o[15:8];
    end
  end

  typedef struct {
    logic             we;
    logic [1:0]       siz;
    logic             sgn;
    logic [63:0]      adr;
    logic [63:0]      wd;
    logic [3:0][5:0]  pa;   // preload addresses, index 3 listed first
    logic [3:0][15:0] pd;
    int               ack;
    logic [63:0]      rd;
    int               nb;
    logic [19:0]      ba;   // first beat halfword address
    logic [3:0][15:0] bd;   // expected store data per beat, beat 3 listed first
    logic             ub;
    logic             lb;
  } vec_t;

  int total = 0;
  int bad = 0;
  int we_low, leak;
  logic [38:0] exp_q[$];
  vec_t vecs[13];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard: each SETUP cycle is one beat, compared against the front of exp_q.
  task automatic observe(input logic cur_we);
    logic [38:0] obs;
    if (!sram_cs_no && sram_oe_no && sram_we_no) begin
      obs = {sram_adr_o, cur_we ? sram_dat_o : 16'h0000, sram_ub_no, sram_lb_no, sram_dat_oe_o};
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL beat_extra: got %h expected none", obs);
      end else begin
        check("beat", 64'(obs), 64'(exp_q.pop_front()));
      end
    end
    if (!sram_we_no) we_low++;
    if (!dack_o && ddat_o != 64'd0) leak++;
  endtask

  task automatic run_access(input logic we, input logic [1:0] siz, input logic sgn,
                            input logic [63:0] adr, input logic [63:0] wd, input int drop_cyc,
                            output int ack_cyc, output logic [63:0] rd);
    ack_cyc = -1;
    rd      = 64'd0;
    we_low  = 0;
    leak    = 0;
    dcyc = 1'b1; dstb = 1'b1; dwe = we; dsiz = siz; dsigned = sgn; dadr = adr; ddat_in = wd;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (n == drop_cyc) begin dcyc = 1'b0; dstb = 1'b0; end
      observe(we);
      if (dack_o) begin
        ack_cyc = n;
        rd = ddat_o;
        dcyc = 1'b0;
        dstb = 1'b0;
        break;
      end
    end
    if (ack_cyc > 0) begin
      @(posedge clk); #1;
      observe(we);
    end
    dcyc = 1'b0;
    dstb = 1'b0;
  endtask

  task automatic push_beats(input logic we, input logic [19:0] ba, input int nb,
                            input logic [3:0][15:0] bd, input logic ub, input logic lb);
    for (int j = 0; j < nb; j++)
      exp_q.push_back({ba + 20'(j), we ? bd[j] : 16'h0000, ub, lb, we});
  endtask

  initial begin
    int ack;
    int acks;
    logic [63:0] rd;
    vecs[0]  = '{we:1, siz:3, sgn:0, adr:64'h10, wd:64'h1122_3344_5566_7788, pa:{6'd63,6'd63,6'd63,6'd63},
                 pd:'0, ack:13, rd:64'd0, nb:4, ba:20'h8, bd:{16'h1122,16'h3344,16'h5566,16'h7788}, ub:0, lb:0};
    vecs[1]  = '{we:1, siz:0, sgn:0, adr:64'h21, wd:64'hAB, pa:{6'd63,6'd63,6'd63,6'd63},
                 pd:'0, ack:4, rd:64'd0, nb:1, ba:20'h10, bd:{16'h0,16'h0,16'h0,16'hABAB}, ub:0, lb:1};
    vecs[2]  = '{we:0, siz:0, sgn:1, adr:64'h13, wd:64'd0, pa:{6'd63,6'd63,6'd63,6'd9},
                 pd:{16'h0,16'h0,16'h0,16'h80FF}, ack:4, rd:64'hFFFF_FFFF_FFFF_FF80, nb:1, ba:20'h9, bd:'0, ub:0, lb:0};
    vecs[3]  = '{we:0, siz:0, sgn:0, adr:64'h13, wd:64'd0, pa:{6'd63,6'd63,6'd63,6'd9},
                 pd:{16'h0,16'h0,16'h0,16'h80FF}, ack:4, rd:64'h80, nb:1, ba:20'h9, bd:'0, ub:0, lb:0};
    vecs[4]  = '{we:0, siz:0, sgn:1, adr:64'h12, wd:64'd0, pa:{6'd63,6'd63,6'd63,6'd9},
                 pd:{16'h0,16'h0,16'h0,16'h80FF}, ack:4, rd:64'hFFFF_FFFF_FFFF_FFFF, nb:1, ba:20'h9, bd:'0, ub:0, lb:0};
    vecs[5]  = '{we:0, siz:2, sgn:1, adr:64'h12, wd:64'd0, pa:{6'd63,6'd63,6'd9,6'd8},
                 pd:{16'h0,16'h0,16'h8000,16'h0000}, ack:7, rd:64'hFFFF_FFFF_8000_0000, nb:2, ba:20'h8, bd:'0, ub:0, lb:0};
    vecs[6]  = '{we:0, siz:2, sgn:0, adr:64'h12, wd:64'd0, pa:{6'd63,6'd63,6'd9,6'd8},
                 pd:{16'h0,16'h0,16'h8000,16'h0000}, ack:7, rd:64'h0000_0000_8000_0000, nb:2, ba:20'h8, bd:'0, ub:0, lb:0};
    vecs[7]  = '{we:0, siz:1, sgn:1, adr:64'h21, wd:64'd0, pa:{6'd63,6'd63,6'd63,6'd16},
                 pd:{16'h0,16'h0,16'h0,16'hF234}, ack:4, rd:64'hFFFF_FFFF_FFFF_F234, nb:1, ba:20'h10, bd:'0, ub:0, lb:0};
    vecs[8]  = '{we:0, siz:3, sgn:1, adr:64'h17, wd:64'd0, pa:{6'd11,6'd10,6'd9,6'd8},
                 pd:{16'hF567,16'h0123,16'hDEAD,16'hBEEF}, ack:13, rd:64'hF567_0123_DEAD_BEEF, nb:4, ba:20'h8, bd:'0, ub:0, lb:0};
    vecs[9]  = '{we:1, siz:2, sgn:0, adr:64'h36, wd:64'hCAFE_BABE, pa:{6'd63,6'd63,6'd63,6'd63},
                 pd:'0, ack:7, rd:64'd0, nb:2, ba:20'h1A, bd:{16'h0,16'h0,16'hCAFE,16'hBABE}, ub:0, lb:0};
    vecs[10] = '{we:1, siz:1, sgn:0, adr:64'h09, wd:64'h5A5A_1234, pa:{6'd63,6'd63,6'd63,6'd63},
                 pd:'0, ack:4, rd:64'd0, nb:1, ba:20'h4, bd:{16'h0,16'h0,16'h0,16'h1234}, ub:0, lb:0};
    vecs[11] = '{we:1, siz:0, sgn:0, adr:64'h20, wd:64'hFFCD, pa:{6'd63,6'd63,6'd63,6'd63},
                 pd:'0, ack:4, rd:64'd0, nb:1, ba:20'h10, bd:{16'h0,16'h0,16'h0,16'hCDCD}, ub:1, lb:0};
    vecs[12] = '{we:0, siz:1, sgn:0, adr:64'h20, wd:64'd0, pa:{6'd63,6'd63,6'd63,6'd16},
                 pd:{16'h0,16'h0,16'h0,16'h9F01}, ack:4, rd:64'h9F01, nb:1, ba:20'h10, bd:'0, ub:0, lb:0};

    // clock/reset
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    reset_n = 1'b0; dcyc = 1'b0; dstb = 1'b0; dwe = 1'b0; dsiz = 2'd0; dsigned = 1'b0;
    dadr = 64'd0; ddat_in = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs", 64'(sram_cs_no), 64'd1);
    check("rst_oe", 64'(sram_oe_no), 64'd1);
    check("rst_we", 64'(sram_we_no), 64'd1);
    check("rst_lanes", 64'({sram_ub_no, sram_lb_no}), 64'd3);
    check("rst_dat_oe", 64'(sram_dat_oe_o), 64'd0);
    check("rst_dack", 64'(dack_o), 64'd0);
    check("rst_ddat", ddat_o, 64'd0);
    check("rst_adr_dat", 64'({sram_adr_o, sram_dat_o}), 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 13; v++) begin
      for (int j = 0; j < 4; j++) mem[vecs[v].pa[j]] = vecs[v].pd[j];
      push_beats(vecs[v].we, vecs[v].ba, vecs[v].nb, vecs[v].bd, vecs[v].ub, vecs[v].lb);
      run_access(vecs[v].we, vecs[v].siz, vecs[v].sgn, vecs[v].adr, vecs[v].wd, -1, ack, rd);
      check($sformatf("v%0d_ack_cycle", v), 64'(ack), 64'(vecs[v].ack));
      check($sformatf("v%0d_ddat", v), rd, vecs[v].rd);
      check($sformatf("v%0d_beats_left", v), 64'(exp_q.size()), 64'd0);
      check($sformatf("v%0d_we_low_cycles", v), 64'(we_low), 64'(vecs[v].we ? vecs[v].nb * 2 : 0));
      check($sformatf("v%0d_ddat_idle", v), 64'(leak), 64'd0);
      exp_q.delete();
    end

    // Reset during the strobe of beat 2 of a dword store
    push_beats(1'b1, 20'h8, 3, {16'h0, 16'h3344, 16'h5566, 16'h7788}, 1'b0, 1'b0);
    we_low = 0; leak = 0;
    dcyc = 1'b1; dstb = 1'b1; dwe = 1'b1; dsiz = 2'd3; dsigned = 1'b0;
    dadr = 64'h10; ddat_in = 64'h1122_3344_5566_7788;
    acks = 0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      observe(1'b1);
      if (dack_o) acks++;
    end
    check("t5_we_low_beat2", 64'(sram_we_no), 64'd0);
    #2 reset_n = 1'b0;
    #1;
    check("t5_async_we", 64'(sram_we_no), 64'd1);
    check("t5_async_cs", 64'(sram_cs_no), 64'd1);
    check("t5_async_dat_oe", 64'(sram_dat_oe_o), 64'd0);
    dcyc = 1'b0; dstb = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      observe(1'b0);
      if (dack_o) acks++;
    end
    check("t5_no_ack", 64'(acks), 64'd0);
    check("t5_beats_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    mem[9] = 16'h80FF;
    push_beats(1'b0, 20'h9, 1, '0, 1'b0, 1'b0);
    run_access(1'b0, 2'd0, 1'b1, 64'h13, 64'd0, -1, ack, rd);
    check("t5_after_ack_cycle", 64'(ack), 64'd4);
    check("t5_after_ddat", rd, 64'hFFFF_FFFF_FFFF_FF80);
    exp_q.delete();

    // dcyc_i dropped during beat 1 of a dword load
    mem[8] = 16'h1111; mem[9] = 16'h2222; mem[10] = 16'h3333; mem[11] = 16'h4444;
    push_beats(1'b0, 20'h8, 2, '0, 1'b0, 1'b0);
    run_access(1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 4, ack, rd);
    check("t6_abort_no_ack", 64'(ack), 64'hFFFF_FFFF_FFFF_FFFF);
    check("t6_abort_beats_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    push_beats(1'b0, 20'h8, 4, '0, 1'b0, 1'b0);
    run_access(1'b0, 2'd3, 1'b0, 64'h10, 64'd0, -1, ack, rd);
    check("t6_retry_ack_cycle", 64'(ack), 64'd13);
    check("t6_retry_ddat", rd, 64'h4444_3333_2222_1111);
    check("t6_retry_beats_left", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
